// File: rtl/mul_job_dispatcher.sv
// rtl/mul_job_dispatcher.sv - operand-pair queue feeding a 16x16 multiplier, one job in flight
// The FIFO stays a separate module so the dispatcher FSM only ever sees a head entry and a pop.

module mul_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [W-1:0]             s_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [W-1:0]             m_tdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  // Readiness depends only on fullness, never on a same-cycle pop.
  assign s_tready = (level_q != FULL);
  assign m_tvalid = (level_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end
endmodule

module mul_job_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  output logic                     mul_clr,
  output logic                     mul_start,
  output logic [15:0]              mul_a,
  output logic [15:0]              mul_b,
  input  logic                     mul_done,
  input  logic [31:0]              mul_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_res,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_START, S_WAIT, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        clr_q, clr_d;
  logic        start_q, start_d;
  logic        out_valid_q, out_valid_d;
  logic        head_valid;
  logic [31:0] head_data;
  logic        pop_ready;

  mul_job_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (in_valid),
    .s_tready (in_ready),
    .s_tdata  ({in_a, in_b}),
    .m_tvalid (head_valid),
    .m_tready (pop_ready),
    .m_tdata  (head_data),
    .level    (fifo_level)
  );

  assign pop_ready = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (head_valid) begin
          op_d    = head_data;
          state_d = S_CLR;
        end
      end
      S_CLR:   state_d = S_START;
      S_START: state_d = S_WAIT;
      // mul_done is only looked at here, so a level left high by a prior job is harmless.
      S_WAIT: begin
        if (mul_done) begin
          res_d   = mul_res;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    clr_d       = (state_d == S_CLR);
    start_d     = (state_d == S_START);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      res_q       <= '0;
      clr_q       <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_q       <= res_d;
      clr_q       <= clr_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mul_clr   = clr_q;
  assign mul_start = start_q;
  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign mul_a     = op_q[31:16];
  assign mul_b     = op_q[15:0];
endmodule

// File: tb/tb_mul_job_dispatcher.sv
// tb/tb_mul_job_dispatcher.sv - directed bench with a job-timeline model and per-cycle compare
module tb_mul_job_dispatcher;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        mul_clr, mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  fifo_level;

  mul_job_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_clr    (mul_clr),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_res    (mul_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit sticky   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a queue of pairs plus the timeline of the one job in flight.
  logic [31:0] m_q[$];
  bit          m_busy = 1'b0;
  bit          m_rdy  = 1'b0;
  int          m_age  = 0;
  logic [31:0] m_op   = '0;
  logic [31:0] m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_rdy  = 1'b0;
      m_age  = 0;
      m_op   = '0;
      m_res  = '0;
    end else begin
      int sz;
      bit do_pop, do_push;
      sz      = m_q.size();
      do_pop  = !m_busy && sz > 0;
      do_push = (in_valid === 1'b1) && sz != DEPTH;
      if (m_busy) begin
        if (m_rdy) begin
          if (out_ready) begin
            m_busy = 1'b0;
            m_rdy  = 1'b0;
          end
        end else if (m_age >= 3) begin
          if (mul_done) begin
            m_rdy = 1'b1;
            m_res = 32'(m_op[31:16]) * 32'(m_op[15:0]);
          end
        end else begin
          m_age++;
        end
      end
      if (do_pop) begin
        m_op   = m_q.pop_front();
        m_busy = 1'b1;
        m_age  = 1;
      end
      if (do_push) m_q.push_back({in_a, in_b});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("mul_clr",    32'(mul_clr),    32'(m_busy && m_age == 1));
      chk("mul_start",  32'(mul_start),  32'(m_busy && m_age == 2));
      chk("out_valid",  32'(out_valid),  32'(m_rdy));
      chk("out_res",    out_res,         m_res);
      chk("mul_ab",     {mul_a, mul_b},  m_op);
    end
  end

  // Multiplier stand-in: done four cycles after start; optionally holds done high.
  logic [15:0] ea = '0, eb = '0;
  int          mcnt = 0;
  initial begin
    logic st;
    logic [15:0] pa, pb;
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(posedge clk);
      st = mul_start;
      pa = mul_a;
      pb = mul_b;
      #1;
      if (st === 1'b1) begin
        mcnt = 4;
        ea = pa;
        eb = pb;
        mul_done = 1'b0;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mul_done = 1'b1;
          mul_res  = 32'(ea) * 32'(eb);
        end
      end else if (!sticky) begin
        mul_done = 1'b0;
      end
    end
  end

  int          hs_cnt = 0;
  int          clr_cnt = 0;
  int          start_cnt = 0;
  bit          fifth_seen = 1'b0;
  logic [31:0] last_res = '0;

  always @(posedge clk) begin
    if (chk_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        hs_cnt++;
        last_res = out_res;
      end
      if (mul_clr === 1'b1) clr_cnt++;
      if (mul_start === 1'b1) begin
        start_cnt++;
        if (mul_a == 16'h1234 && mul_b == 16'h5678) fifth_seen = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int max);
    for (int i = 0; i < max; i++) begin
      if (out_valid === 1'b1) break;
      tick();
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_hs(input string nm, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (hs_cnt >= target) break;
      tick();
    end
    chk(nm, 32'(hs_cnt), 32'(target));
  endtask

  initial begin
    int c0, s0, h0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_level",     32'(fifo_level), 32'd0);
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_out_res",   out_res,         32'h0);
    chk("rst_pulses",    32'({mul_clr, mul_start}), 32'd0);

    // Single job, result held under backpressure.
    c0 = clr_cnt;
    s0 = start_cnt;
    push(16'h0003, 16'h0005);
    wait_out("t1_wait", 30);
    repeat (3) tick();
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_res", out_res, 32'h0000000F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_released", 32'(out_valid), 32'd0);
    chk("t1_clr_pulses", 32'(clr_cnt - c0), 32'd1);
    chk("t1_start_pulses", 32'(start_cnt - s0), 32'd1);

    // Fill while a result is stalled, then overflow, then drain in order.
    push(16'h0002, 16'h0003);
    wait_out("t2_job0", 30);
    push(16'h9CE3, 16'hD93A);
    push(16'h8BE6, 16'h5F81);
    push(16'h6A9D, 16'hAE83);
    push(16'h4B73, 16'hE0C3);
    chk("t2_full_level", 32'(fifo_level), 32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    push(16'h1234, 16'h5678);
    chk("t2_overflow_level", 32'(fifo_level), 32'd4);
    h0 = hs_cnt;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t2_after_pop", 32'(fifo_level), 32'd3);
    wait_hs("t2_drain", h0 + 5, 300);
    chk("t2_last_res", last_res, 32'h423E1899);
    chk("t2_fifth_issued", 32'(fifth_seen), 32'd0);

    // Sticky done must not short-circuit the next job.
    sticky = 1'b1;
    h0 = hs_cnt;
    push(16'h0002, 16'h0007);
    wait_hs("t3_job1", h0 + 1, 40);
    chk("t3_res1", last_res, 32'h0000000E);
    push(16'h0003, 16'h0009);
    wait_hs("t3_job2", h0 + 2, 40);
    chk("t3_res2", last_res, 32'h0000001B);
    sticky = 1'b0;
    tick();

    // Reset while waiting with two pairs queued.
    push(16'h0101, 16'h0202);
    push(16'h0011, 16'h0022);
    push(16'h0033, 16'h0044);
    for (int i = 0; i < 20; i++) begin
      if (mul_start === 1'b1) break;
      tick();
    end
    tick();
    chk("t4_pre_rst_level", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_out_res", out_res, 32'h0);
    chk("t4_mul_ab", {mul_a, mul_b}, 32'h0);
    h0 = hs_cnt;
    repeat (12) tick();
    chk("t4_no_output", 32'(hs_cnt), 32'(h0));

    // Push coinciding with the IDLE pop, then enough traffic to wrap the pointers.
    out_ready = 1'b0;
    h0 = hs_cnt;
    push(16'h0005, 16'h0006);
    wait_out("t5_job0", 30);
    push(16'h00A1, 16'h00B2);
    out_ready = 1'b1;
    tick();
    push(16'h00C3, 16'h00D4);
    chk("t5_push_pop_level", 32'(fifo_level), 32'd1);
    push(16'h0102, 16'h0203);
    push(16'h0304, 16'h0405);
    push(16'hFFFF, 16'hFFFF);
    wait_hs("t5_drain", h0 + 6, 400);
    chk("t5_last_res", last_res, 32'hFFFE0001);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mul_job_dispatcher.md
MUL_JOB_DISPATCHER -- requirements
Module: mul_job_dispatcher

Interface
REQ-001 Parameter: DEPTH, 4, operand-queue depth in entries (power of two, >= 2).
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  upstream offers an operand pair.
REQ-005 Port: in_ready  out  1  dispatcher accepts the pair this cycle.
REQ-006 Port: in_a, in_b  in  16 each  operand pair.
REQ-007 Port: mul_clr  out  1  one-cycle reset pulse to the 16x16 multiplier.
REQ-008 Port: mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-009 Port: mul_a, mul_b  out  16 each  operands to the multiplier.
REQ-010 Port: mul_done  in  1  multiplier completion flag (level, may stay high).
REQ-011 Port: mul_res  in  32  multiplier product.
REQ-012 Port: out_valid  out  1  result available.
REQ-013 Port: out_ready  in  1  downstream accepts the result.
REQ-014 Port: out_res  out  32  registered product.
REQ-015 Port: fifo_level  out  clog2(DEPTH)+1  entries currently queued.

Function
REQ-016 Queue SHALL be a DEPTH-entry FIFO of {a,b}; push when in_valid && in_ready.
REQ-017 in_ready SHALL equal !full (fifo_level != DEPTH), independent of same-cycle pop.
REQ-018 Push and pop in the same cycle SHALL leave fifo_level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-019 in_valid while full SHALL be ignored; queue contents unchanged.
REQ-020 FSM states SHALL be IDLE, CLR, START, WAIT, OUT.
REQ-021 IDLE: if fifo_level != 0, pop head into operand register, go CLR; else stay.
REQ-022 CLR: mul_clr = 1 for exactly this cycle; go START.
REQ-023 START: mul_start = 1 for exactly this cycle; go WAIT.
REQ-024 WAIT: on mul_done = 1, load out_res <= mul_res, go OUT; else stay (no timeout).
REQ-025 mul_done SHALL be ignored in every state except WAIT (stale high done from a prior job has no effect).
REQ-026 OUT: out_valid = 1; on out_ready = 1 go IDLE; out_res SHALL hold stable while out_valid && !out_ready.
REQ-027 mul_a/mul_b SHALL be driven from the operand register and stay constant from CLR through OUT.
REQ-028 mul_clr, mul_start, out_valid SHALL be registered-state decodes, glitch-free, never simultaneously high.
REQ-029 Latency: pair pushed at edge N into an empty queue while in IDLE -> CLR at N+1, START at N+2, WAIT from N+3; out_valid one cycle after the edge sampling mul_done = 1 in WAIT.
REQ-030 Jobs SHALL complete strictly in push order; one job in flight at a time.
REQ-031 Queue SHALL continue accepting pushes in all FSM states while not full.

Reset
REQ-032 rst = 1 at an edge SHALL empty the FIFO (fifo_level = 0), force IDLE, and zero out_res, mul_a, mul_b, operand register.
REQ-033 During and after reset until next job: mul_clr = 0, mul_start = 0, out_valid = 0, in_ready = 1.
REQ-034 Reset mid-job (CLR/START/WAIT/OUT) SHALL abandon the job and all queued pairs; no result is emitted for them.

Verification
REQ-035 Single job: push (0x0003, 0x0005), model asserts mul_done 4 cycles after mul_start with mul_res = 0x0000000F -> mul_clr, mul_start each exactly one cycle, out_res = 0x0000000F, out_valid until out_ready.
REQ-036 Order/backpressure: push 4 pairs (0x9CE3,0xD93A),(0x8BE6,0x5F81),(0x6A9D,0xAE83),(0x4B73,0xE0C3) back-to-back with out_ready = 0 -> in_ready = 0 after 4th push, fifo_level = 4 then 3 after first pop; results emerge in push order once out_ready = 1.
REQ-037 Overflow: 5th push while full -> ignored, fifo_level stays 4, 5th pair never issued.
REQ-038 Sticky done: model holds mul_done = 1 after job 1 -> job 2 still passes CLR and START, no capture before WAIT; out_res updates only to job 2's mul_res.
REQ-039 Reset mid-WAIT with 2 pairs queued -> next cycle fifo_level = 0, IDLE, out_valid = 0, out_res = 0x00000000; subsequent mul_done = 1 produces no output.
REQ-040 Simultaneous push/pop: push at the edge IDLE pops with fifo_level = 1 -> fifo_level remains 1, wrap-around beyond DEPTH pushes preserves data.
